// File: rtl/nios_ii_pio_pkg.sv
// Shared constants for the Nios II input PIO: register word addresses and
// edge-capture mode encodings, plus the per-bit edge qualification helper.
package nios_ii_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_MODE    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam logic [1:0] MODE_RISE = 2'd0;
  localparam logic [1:0] MODE_FALL = 2'd1;
  localparam logic [1:0] MODE_ANY  = 2'd2;
  localparam logic [1:0] MODE_NONE = 2'd3;

  function automatic logic edge_hit(input logic [1:0] mode, input logic cur, input logic nxt);
    case (mode)
      MODE_RISE: edge_hit = ~cur &  nxt;
      MODE_FALL: edge_hit =  cur & ~nxt;
      MODE_ANY:  edge_hit =  cur ^  nxt;
      default:   edge_hit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nios_ii_pio_debounce.sv
// One input bit: 2-flop synchroniser, optional debounce counter and stable
// register. stable_nxt exposes the value stable takes at the coming edge.
module nios_ii_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic stable,
  output logic stable_nxt
);

  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (reset) sync <= 2'b00;
    else       sync <= {sync[0], in_bit};
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign stable_nxt = sync[1];
    end else begin : g_count
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
      logic [CW-1:0] cnt;
      logic          differ;

      // The new value must be seen on DEBOUNCE_CYCLES+1 consecutive edges.
      assign differ     = sync[1] ^ stable;
      assign stable_nxt = (differ && cnt == CNT_MAX) ? sync[1] : stable;

      always_ff @(posedge clk) begin
        if (reset)                       cnt <= '0;
        else if (!differ || cnt == CNT_MAX) cnt <= '0;
        else                             cnt <= cnt + 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) stable <= 1'b0;
    else       stable <= stable_nxt;
  end

endmodule

// File: rtl/nios_ii_pio_in_edge.sv
// Avalon-MM input PIO: debounced DATA, edge-capture with selectable mode,
// maskable level irq. Four-word slave, registered read data.
module nios_ii_pio_in_edge
  import nios_ii_pio_pkg::*;
#(
  parameter int         WIDTH           = 8,
  parameter int         DEBOUNCE_CYCLES = 0,
  parameter logic [1:0] EDGE_MODE_RESET = 2'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable, stable_nxt, hit;
  logic [WIDTH-1:0] irq_mask, edge_cap;
  logic [1:0]       mode;
  logic [31:0]      rd_mux;
  logic             wr;
  logic             unused_wdata;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_bit
      nios_ii_pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk        (clk),
        .reset      (reset),
        .in_bit     (in_port[g]),
        .stable     (stable[g]),
        .stable_nxt (stable_nxt[g])
      );
      assign hit[g] = edge_hit(mode, stable[g], stable_nxt[g]);
    end
  endgenerate

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
      ADDR_MODE:    rd_mux[1:0]       = mode;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
      default:      rd_mux[WIDTH-1:0] = edge_cap;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode     <= EDGE_MODE_RESET;
      irq_mask <= '0;
      edge_cap <= '0;
      readdata <= '0;
    end else begin
      if (wr && address == ADDR_MODE)    mode     <= writedata[1:0];
      if (wr && address == ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
      // A new edge on a bit being cleared in the same cycle stays captured.
      if (wr && address == ADDR_EDGECAP) edge_cap <= (edge_cap & ~writedata[WIDTH-1:0]) | hit;
      else                               edge_cap <= edge_cap | hit;
      readdata <= rd_mux;
    end
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_nios_ii_pio_in_edge.sv
// Directed bench: one bypassed instance and one DEBOUNCE_CYCLES=4 instance
// share the bus; expectations go through a scoreboard queue.
module tb_nios_ii_pio_in_edge;
  import nios_ii_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset, chipselect, write_n;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [7:0]  in0, in4;
  logic [31:0] rd0, rd4;
  logic        irq0, irq4;

  always #5 clk = ~clk;

  nios_ii_pio_in_edge #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_MODE_RESET(2'd0)) u_dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in0),
    .readdata(rd0), .irq(irq0));

  nios_ii_pio_in_edge #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE_RESET(2'd2)) u_dut4 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in4),
    .readdata(rd4), .irq(irq4));

  string       tag_q[$];
  logic [31:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic expect_push(input string tag, input logic [31:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic check_pop(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=%h", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    expect_push(tag, e);
    check_pop(obs);
  endtask

  task automatic rd(input bit d4, input logic [1:0] a, input logic [31:0] e, input string tag);
    address = a;
    expect_push(tag, e);
    tick();
    tick();
    check_pop(d4 ? rd4 : rd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = '0; in0 = '0; in4 = '0;
    idle(2);
    reset = 1'b0;

    rd(0, ADDR_DATA,    32'h0, "rst_data");
    rd(0, ADDR_MODE,    32'h0, "rst_mode");
    rd(0, ADDR_IRQMASK, 32'h0, "rst_mask");
    rd(0, ADDR_EDGECAP, 32'h0, "rst_ecap");
    chk("rst_irq0", irq0, 0);
    rd(1, ADDR_MODE,    32'h2, "rst_mode4");
    chk("rst_irq4", irq4, 0);

    // Bypassed debounce: stable and capture three edges after the step.
    wr(ADDR_IRQMASK, 32'h01);
    wr(ADDR_MODE, 32'h0);
    address = ADDR_DATA;
    in0 = 8'h05;
    tick(); tick();
    chk("irq0_edge2", irq0, 0);
    tick();
    chk("irq0_edge3", irq0, 1);
    tick();
    chk("data0_step", rd0, 32'h05);
    rd(0, ADDR_EDGECAP, 32'h05, "ecap0_step");
    wr(ADDR_EDGECAP, 32'h01);
    rd(0, ADDR_EDGECAP, 32'h04, "ecap0_w1c");
    chk("irq0_cleared", irq0, 0);
    wr(ADDR_DATA, 32'hFF);
    rd(0, ADDR_DATA, 32'h05, "data_ro");
    wr(ADDR_IRQMASK, 32'hFFFF_FFFF);
    rd(0, ADDR_IRQMASK, 32'hFF, "mask_width");
    wr(ADDR_IRQMASK, 32'h01);

    // Debounced: a 3-cycle glitch is rejected.
    in4 = 8'h01;
    idle(3);
    in4 = 8'h00;
    idle(10);
    rd(1, ADDR_DATA,    32'h0, "glitch_data");
    rd(1, ADDR_EDGECAP, 32'h0, "glitch_ecap");
    chk("glitch_irq", irq4, 0);

    // Debounced step: stable updates on edge 2+4+1.
    address = ADDR_DATA;
    in4 = 8'h01;
    idle(6);
    chk("irq4_edge6", irq4, 0);
    tick();
    chk("irq4_edge7", irq4, 1);
    chk("data4_edge7", rd4, 32'h0);
    tick();
    chk("data4_edge8", rd4, 32'h1);
    in4 = 8'h00;
    idle(12);
    rd(1, ADDR_DATA,    32'h0, "data4_fall");
    rd(1, ADDR_EDGECAP, 32'h1, "ecap4_rise_only");
    wr(ADDR_EDGECAP, 32'hFF);
    rd(1, ADDR_EDGECAP, 32'h0, "ecap4_clear");

    // Falling mode.
    wr(ADDR_EDGECAP, 32'hFF);
    wr(ADDR_MODE, 32'h1);
    rd(0, ADDR_MODE, 32'h1, "mode_fall");
    in0 = 8'h0D;
    idle(5);
    rd(0, ADDR_EDGECAP, 32'h00, "fall_ignores_rise");
    in0 = 8'h05;
    idle(5);
    rd(0, ADDR_EDGECAP, 32'h08, "fall_bit3");

    // No-capture mode.
    wr(ADDR_MODE, 32'h3);
    wr(ADDR_EDGECAP, 32'hFF);
    in0 = 8'hFA;
    idle(5);
    in0 = 8'h05;
    idle(5);
    rd(0, ADDR_EDGECAP, 32'h00, "mode_none");
    rd(0, ADDR_DATA,    32'h05, "data_none");

    // Set beats a simultaneous write-1-clear.
    wr(ADDR_MODE, 32'hFFFF_FFFC);
    rd(0, ADDR_MODE, 32'h0, "mode_upper_ignored");
    in0 = 8'h01;
    idle(5);
    wr(ADDR_EDGECAP, 32'hFF);
    in0 = 8'h05;
    idle(2);
    wr(ADDR_EDGECAP, 32'h04);
    rd(0, ADDR_EDGECAP, 32'h04, "set_wins");
    wr(ADDR_EDGECAP, 32'h04);
    rd(0, ADDR_EDGECAP, 32'h00, "clear_bit2");

    // Any-edge mode catches a falling bit.
    wr(ADDR_MODE, 32'h2);
    in0 = 8'h04;
    idle(5);
    rd(0, ADDR_EDGECAP, 32'h01, "any_fall");
    in0 = 8'h05;

    // Reset in the middle of a debounce count.
    wr(ADDR_MODE, 32'h0);
    wr(ADDR_EDGECAP, 32'hFF);
    in4 = 8'h01;
    idle(10);
    chk("irq4_pre_rst", irq4, 1);
    address = ADDR_EDGECAP;
    in4 = 8'h00;
    idle(4);
    chk("rdata4_pre_rst", rd4, 32'h1);
    reset = 1'b1;
    tick();
    chk("irq4_rst", irq4, 0);
    chk("rdata4_rst", rd4, 32'h0);
    chk("irq0_rst", irq0, 0);
    reset = 1'b0;
    rd(1, ADDR_DATA,    32'h0, "rst4_data");
    rd(1, ADDR_MODE,    32'h2, "rst4_mode");
    rd(1, ADDR_IRQMASK, 32'h0, "rst4_mask");
    idle(10);
    rd(1, ADDR_EDGECAP, 32'h0, "rst4_no_edge");
    rd(0, ADDR_EDGECAP, 32'h05, "post_reset_rise");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios_ii_pio_in_edge.md
# nios_ii_pio_in_edge

Parametrised Avalon-MM input PIO for the Nios II system, successor to the fixed 8-bit keyboard data port. Synchronises and debounces a WIDTH-bit external bus, exposes the stable value, captures per-bit edges in a software-selectable mode, and raises a maskable level interrupt to the CPU. It sits on the Nios II data master as a 4-word slave, one instance per input bus (keyboard data, buttons, switches).

## Interface
Parameters:
- WIDTH, 8, input bus width, 1..32
- DEBOUNCE_CYCLES, 0, consecutive stable cycles required before a new value is accepted; 0 bypasses debounce
- EDGE_MODE_RESET, 2'd0, reset value of the edge-mode register

Ports:
- clk  in  1  system clock; one clock domain only
- reset  in  1  synchronous, active-high reset
- address  in  2  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous external input
- readdata  out  32  registered read data
- irq  out  1  level interrupt, active-high

## Operation
- Register map (word): 0 DATA (RO, stable value, zero-extended); 1 MODE (RW, bits [1:0]: 0 rising, 1 falling, 2 any, 3 none); 2 IRQMASK (RW, WIDTH bits); 3 EDGECAPTURE (R, write-1-to-clear per bit).
- Writes to DATA ignored; unused upper writedata bits ignored; unused readdata bits read 0.
- Per bit: 2-flop synchroniser -> debounce -> stable register.
- Debounce: per-bit counter, width clog2(DEBOUNCE_CYCLES+1); counts while synchronised bit differs from stable bit, clears to 0 whenever they agree; stable bit toggles on the edge where counter would reach DEBOUNCE_CYCLES, counter then clears. DEBOUNCE_CYCLES=0: stable loads synchroniser output every cycle.
- Edge detect: uses stable bit's current and next value; qualifying transition per MODE sets the EDGECAPTURE bit on the same clock edge the stable bit updates.
- Simultaneous write-1-clear and new edge on the same bit: set wins.
- MODE change takes effect for transitions from the next clock edge; already captured bits unaffected.
- irq = |(EDGECAPTURE & IRQMASK), computed from registers only (no input-combinational path).
- readdata reloaded every cycle from address mux, independent of chipselect (read side effects: none).

## Timing
- Reset: readdata 0, irq 0, sync flops 0, stable 0, counters 0, IRQMASK 0, EDGECAPTURE 0, MODE EDGE_MODE_RESET.
- Post-reset, an input held at 1 produces a rising transition of stable and sets EDGECAPTURE in rising/any mode; software clears EDGECAPTURE during init.
- Read latency 1 cycle: address at edge N -> readdata valid after edge N+1.
- Write takes effect at the sampling edge; readable via readdata one cycle later.
- in_port step to stable update: 2 + DEBOUNCE_CYCLES + 1 edges (3 when bypassed); irq asserts same edge as EDGECAPTURE.
- Glitch shorter than DEBOUNCE_CYCLES synchronised cycles: no stable change, no capture.
- Reset asserted mid-count: counters and stable clear that edge; no edge captured on the reset cycle.

## Structure
- Package nios_ii_pio_pkg: register address constants (ADDR_DATA..ADDR_EDGECAP), edge mode encodings (MODE_RISE, MODE_FALL, MODE_ANY, MODE_NONE).
- Sub-module nios_ii_pio_debounce: one bit of synchroniser + counter + stable register, outputs stable and next-stable; generated WIDTH times.
- Top holds MODE, IRQMASK, EDGECAPTURE, read mux, irq.

## Test plan
- Reset with in_port=8'h00, DEBOUNCE_CYCLES=0: read addr 0..3 -> 0,0,0,0; irq=0.
- DEBOUNCE_CYCLES=0, MODE=0, IRQMASK=8'h01, in_port 0->8'h05: DATA=8'h05 after 3 edges, EDGECAPTURE=8'h05, irq=1 same edge; write 8'h01 to addr 3 -> EDGECAPTURE=8'h04, irq=0.
- DEBOUNCE_CYCLES=4, bit0 pulse 3 synchronised cycles -> DATA stays 0, no capture; pulse 6 cycles -> DATA bit0=1 exactly 2+4+1 edges after step.
- MODE=1, bit3 1->0 -> EDGECAPTURE bit3 set; MODE=3 with any toggle -> EDGECAPTURE unchanged.
- Clear bit2 by write in same cycle a new rising edge on bit2 arrives -> bit2 remains 1.
- Reset asserted mid debounce count -> all registers back to reset values next edge; irq=0.
